// File: rtl/fetch_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fetch_pkg : shared entry type and sizing helper for the instruction fetch unit
// Rev 1.0
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Counters must hold the value DEPTH itself, hence one bit above the index width.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fetch_fifo : DEPTH-entry synchronous prefetch FIFO; flush overrides push/pop
// Rev 1.0
// -----------------------------------------------------------------------------
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type ENTRY_T = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rstf,
  input  logic                   push,
  input  ENTRY_T                 wr_data,
  input  logic                   pop,
  input  logic                   flush,
  output ENTRY_T                 rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  ENTRY_T        mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    do_push  = push & ~flush;
    do_pop   = pop & (count_q != '0) & ~flush;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read out while count is zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign empty   = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// -----------------------------------------------------------------------------
// instr_fetch_unit : pipelined sequential fetch with prefetch FIFO and redirect flush
// Rev 1.0
// -----------------------------------------------------------------------------
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rstf,
  output logic [XLEN-1:0] ibus_req_addr,
  output logic            ibus_req_valid,
  input  logic            ibus_req_ready,
  input  logic [XLEN-1:0] ibus_rsp_data,
  input  logic            ibus_rsp_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int unsigned     CW      = cnt_width(DEPTH);
  localparam logic [XLEN-1:0] STEP    = XLEN'(INSTR_BYTES);
  localparam logic [CW:0]     CREDITS = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     in_use;
  logic            fifo_empty;
  logic            fifo_push;
  logic            req_fire;
  logic            rsp_keep;
  logic [XLEN-1:0] target_pc;
  entry_t          push_entry;
  entry_t          head_entry;

  // Credits cover both in-flight and buffered words, so a push can never overflow.
  assign in_use         = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign ibus_req_valid = rstf & ~redirect_valid & (in_use < CREDITS);
  assign ibus_req_addr  = fetch_pc_q;
  assign req_fire       = ibus_req_valid & ibus_req_ready;
  assign rsp_keep       = ibus_rsp_valid & (drop_q == '0);
  assign target_pc      = {redirect_pc[XLEN-1:2], 2'b00};

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(ibus_rsp_valid);
    drop_d        = drop_q;
    fifo_push     = 1'b0;
    if (redirect_valid) begin
      // No request fires during a redirect; every still-unanswered word is stale.
      fetch_pc_d = target_pc;
      rsp_pc_d   = target_pc;
      drop_d     = outstanding_d;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + STEP;
      if (rsp_keep) begin
        rsp_pc_d  = rsp_pc_q + STEP;
        fifo_push = 1'b1;
      end else if (ibus_rsp_valid) begin
        drop_d = drop_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  assign push_entry.pc    = rsp_pc_q;
  assign push_entry.instr = ibus_rsp_data;

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_T (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rstf    (rstf),
    .push    (fifo_push),
    .wr_data (push_entry),
    .pop     (instr_ready),
    .flush   (redirect_valid),
    .rd_data (head_entry),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  assign instr       = head_entry.instr;
  assign instr_pc    = head_entry.pc;
  assign instr_valid = ~fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit : transaction-level model of the fetch front end vs the DUT
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk  = 1'b0;
  logic        rstf = 1'b1;
  logic [31:0] ibus_req_addr;
  logic        ibus_req_valid;
  logic        ibus_req_ready = 1'b0;
  logic [31:0] ibus_rsp_data  = '0;
  logic        ibus_rsp_valid = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready    = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;

  instr_fetch_unit #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rstf           (rstf),
    .ibus_req_addr  (ibus_req_addr),
    .ibus_req_valid (ibus_req_valid),
    .ibus_req_ready (ibus_req_ready),
    .ibus_rsp_data  (ibus_rsp_data),
    .ibus_rsp_valid (ibus_rsp_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  // A request on the bus: its address, earliest answer cycle, and whether a redirect orphaned it.
  typedef struct { logic [31:0] addr; int due; bit stale; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

  req_t        inflight[$];
  ent_t        fifo[$];
  logic [31:0] seen[$];
  logic [31:0] m_fetch_pc;
  int          cyc, total, bad, rsp_lat, accepts;
  bit          rsp_hold;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'd7) ^ 32'h5EED_0000;
  endfunction

  function automatic logic [31:0] seen_at(input int i);
    return (seen.size() > i) ? seen[i] : 32'hBAD0_BAD0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive the bus answer, compare all outputs with the model, advance the model.
  task automatic step();
    bit   exp_rv, acc, rsp;
    req_t r;
    req_t nr;
    ent_t ne;
    rsp = (inflight.size() > 0) && !rsp_hold && (inflight[0].due <= cyc);
    ibus_rsp_valid = rsp;
    ibus_rsp_data  = rsp ? mem(inflight[0].addr) : 32'hDEAD_BEEF;
    #1;
    exp_rv = !redirect_valid && ((inflight.size() + fifo.size()) < DEPTH);
    chk("req_valid", 32'(ibus_req_valid), 32'(exp_rv));
    chk("req_addr", ibus_req_addr, m_fetch_pc);
    chk("instr_valid", 32'(instr_valid), 32'(fifo.size() > 0));
    if (fifo.size() > 0) begin
      chk("instr_pc", instr_pc, fifo[0].pc);
      chk("instr", instr, fifo[0].data);
    end
    acc = exp_rv && ibus_req_ready;
    if (acc) accepts++;
    if (redirect_valid) begin
      if (rsp) inflight.delete(0);
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      fifo.delete();
      m_fetch_pc = redirect_pc & ~32'h3;
    end else begin
      if (instr_ready && fifo.size() > 0) begin
        seen.push_back(fifo[0].pc);
        fifo.delete(0);
      end
      if (rsp) begin
        r = inflight[0];
        inflight.delete(0);
        if (!r.stale) begin
          ne.pc   = r.addr;
          ne.data = mem(r.addr);
          fifo.push_back(ne);
        end
      end
      if (acc) begin
        nr.addr  = m_fetch_pc;
        nr.due   = cyc + rsp_lat;
        nr.stale = 1'b0;
        inflight.push_back(nr);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rstf           = 1'b0;
    redirect_valid = 1'b0;
    ibus_req_ready = 1'b0;
    instr_ready    = 1'b0;
    ibus_rsp_valid = 1'b0;
    rsp_hold       = 1'b0;
    rsp_lat        = 1;
    accepts        = 0;
    inflight.delete();
    fifo.delete();
    seen.delete();
    m_fetch_pc = RESET_PC;
    #1;
    chk("rst_req_valid", 32'(ibus_req_valid), 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_req_addr", ibus_req_addr, RESET_PC);
    repeat (2) @(posedge clk);
    #1;
    rstf = 1'b1;
    cyc  = 0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    #2;

    // Streaming on a zero-wait bus
    do_reset();
    ibus_req_ready = 1'b1;
    instr_ready    = 1'b1;
    #1;
    chk("t1_first_valid", 32'(ibus_req_valid), 32'h1);
    chk("t1_first_addr", ibus_req_addr, 32'h0);
    repeat (2) step();
    chk("t1_cyc2_valid", 32'(instr_valid), 32'h1);
    chk("t1_cyc2_pc", instr_pc, 32'h0);
    repeat (8) step();
    chk("t1_throughput", 32'(seen.size()), 32'd8);
    chk("t1_last_pc", seen_at(7), 32'h1C);

    // Decode stalled: credits cap in-flight plus buffered words at DEPTH
    do_reset();
    ibus_req_ready = 1'b1;
    repeat (8) step();
    chk("t2_accepts", 32'(accepts), 32'd4);
    chk("t2_req_blocked", 32'(ibus_req_valid), 32'h0);
    chk("t2_head_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    repeat (6) step();
    chk("t2_pop0", seen_at(0), 32'h0);
    chk("t2_pop1", seen_at(1), 32'h4);
    chk("t2_pop2", seen_at(2), 32'h8);
    chk("t2_pop3", seen_at(3), 32'hC);
    chk("t2_resumed", 32'(accepts > 4), 32'h1);

    // Redirect with two words in flight and one buffered
    do_reset();
    ibus_req_ready = 1'b1;
    repeat (2) step();
    rsp_hold = 1'b1;
    step();
    chk("t3_pre_valid", 32'(instr_valid), 32'h1);
    chk("t3_pre_pc", instr_pc, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    chk("t3_flushed", 32'(instr_valid), 32'h0);
    chk("t3_target_addr", ibus_req_addr, 32'h100);
    rsp_hold    = 1'b0;
    instr_ready = 1'b1;
    repeat (8) step();
    chk("t3_first_pc", seen_at(0), 32'h100);

    // Redirect coinciding with a response and a pop
    do_reset();
    ibus_req_ready = 1'b1;
    instr_ready    = 1'b1;
    repeat (2) step();
    chk("t4_pre_valid", 32'(instr_valid), 32'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0400;
    step();
    redirect_valid = 1'b0;
    chk("t4_flushed", 32'(instr_valid), 32'h0);
    chk("t4_target_addr", ibus_req_addr, 32'h400);
    repeat (6) step();
    chk("t4_first_pc", seen_at(0), 32'h400);
    chk("t4_second_pc", seen_at(1), 32'h404);

    // Back-to-back redirects with slow responses pending
    do_reset();
    ibus_req_ready = 1'b1;
    instr_ready    = 1'b1;
    rsp_lat        = 3;
    repeat (3) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    step();
    redirect_pc    = 32'h0000_0300;
    step();
    redirect_valid = 1'b0;
    repeat (14) step();
    chk("t5_first_pc", seen_at(0), 32'h300);
    chk("t5_second_pc", seen_at(1), 32'h304);

    // Address wrap at the top of the address space
    seen.delete();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    chk("t6_top_addr", ibus_req_addr, 32'hFFFF_FFFC);
    rsp_lat = 1;
    repeat (12) step();
    chk("t6_top_pc", seen_at(0), 32'hFFFF_FFFC);
    chk("t6_wrap_pc", seen_at(1), 32'h0);

    // Asynchronous reset in the middle of a burst
    chk("t7_busy", 32'(instr_valid), 32'h1);
    #2;
    rstf = 1'b0;
    #1;
    chk("t7_async_req_valid", 32'(ibus_req_valid), 32'h0);
    chk("t7_async_instr_valid", 32'(instr_valid), 32'h0);
    chk("t7_async_addr", ibus_req_addr, RESET_PC);
    do_reset();
    ibus_req_ready = 1'b1;
    instr_ready    = 1'b1;
    repeat (5) step();
    chk("t7_restart_pc", seen_at(0), RESET_PC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
